// File: rtl/rv32_pipe_pkg.sv
// ============================================================================
// rv32_pipe_pkg : shared widths, register-index constants and control-bundle
//                 bit positions for the RV32 pipeline slice.
// Revision      : 1.0
// ============================================================================
`default_nettype none

package rv32_pipe_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int CTRL_WIDTH_DEF = 8;
  localparam int REG_IDX_W      = 5;

  localparam logic [REG_IDX_W-1:0] REG_X0 = 5'd0;

  // Bit positions inside the pass-through EX/MEM/WB control bundle
  localparam int CTRL_BIT_MEMWRITE  = 0;
  localparam int CTRL_BIT_ALUSRC    = 1;
  localparam int CTRL_BIT_BRANCH    = 2;
  localparam int CTRL_BIT_JUMP      = 3;
  localparam int CTRL_BIT_MEMTOREG  = 4;
  localparam int CTRL_BIT_ALUOP_LSB = 5;
  localparam int CTRL_BIT_ALUOP_MSB = 7;

endpackage

`default_nettype wire

// File: rtl/hazard_unit.sv
// ============================================================================
// hazard_unit : combinational load-use detector; a resolved branch/jump flush
//               overrides the stall.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hazard_unit
  import rv32_pipe_pkg::*;
(
  input  logic [REG_IDX_W-1:0] i_ex_rd,
  input  logic                 i_ex_mem_read,
  input  logic                 i_ex_valid,
  input  logic [REG_IDX_W-1:0] i_id_rs1,
  input  logic [REG_IDX_W-1:0] i_id_rs2,
  input  logic                 i_id_valid,
  input  logic                 i_flush,
  output logic                 o_stall
);

  logic w_src_match;
  logic w_hazard;

  // A load into x0 can never feed a consumer, so it never stalls
  assign w_src_match = (i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2);
  assign w_hazard    = i_ex_valid && i_ex_mem_read && (i_ex_rd != REG_X0) &&
                       i_id_valid && w_src_match;
  assign o_stall     = w_hazard && !i_flush;

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage : ID/EX pipeline register with load-use bubble insertion and
//               flush. Optional writeback bypass: ID_EX_WB_BYPASS_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage
  import rv32_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CTRL_WIDTH = CTRL_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic [REG_IDX_W-1:0]  i_rs1,
  input  logic [REG_IDX_W-1:0]  i_rs2,
  input  logic [REG_IDX_W-1:0]  i_rd,
  input  logic [DATA_WIDTH-1:0] i_imm,
  input  logic [DATA_WIDTH-1:0] i_Read1,
  input  logic [DATA_WIDTH-1:0] i_Read2,
  input  logic                  i_ctrl_RegWrite,
  input  logic                  i_ctrl_MemRead,
  input  logic [CTRL_WIDTH-1:0] i_ctrl,
  input  logic [REG_IDX_W-1:0]  i_wb_rd,
  input  logic [DATA_WIDTH-1:0] i_wb_WriteData,
  input  logic                  i_wb_RegWrite,
  input  logic                  i_flush,
  output logic                  o_stall,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_pc,
  output logic [REG_IDX_W-1:0]  o_rs1,
  output logic [REG_IDX_W-1:0]  o_rs2,
  output logic [REG_IDX_W-1:0]  o_rd,
  output logic [DATA_WIDTH-1:0] o_imm,
  output logic [DATA_WIDTH-1:0] o_Read1,
  output logic [DATA_WIDTH-1:0] o_Read2,
  output logic                  o_ctrl_RegWrite,
  output logic                  o_ctrl_MemRead,
  output logic [CTRL_WIDTH-1:0] o_ctrl
);

  logic [DATA_WIDTH-1:0] w_read1;
  logic [DATA_WIDTH-1:0] w_read2;
  logic                  w_bubble;

  hazard_unit u_hazard_unit (
    .i_ex_rd       (o_rd),
    .i_ex_mem_read (o_ctrl_MemRead),
    .i_ex_valid    (o_valid),
    .i_id_rs1      (i_rs1),
    .i_id_rs2      (i_rs2),
    .i_id_valid    (i_valid),
    .i_flush       (i_flush),
    .o_stall       (o_stall)
  );

`ifdef ID_EX_WB_BYPASS_EN
  // Register file writes on the same edge it is read; forward the write data
  assign w_read1 = (i_wb_RegWrite && (i_wb_rd != REG_X0) && (i_wb_rd == i_rs1)) ?
                   i_wb_WriteData : i_Read1;
  assign w_read2 = (i_wb_RegWrite && (i_wb_rd != REG_X0) && (i_wb_rd == i_rs2)) ?
                   i_wb_WriteData : i_Read2;
`else
  logic w_unused_wb;
  assign w_unused_wb = ^{i_wb_rd, i_wb_WriteData, i_wb_RegWrite};
  assign w_read1     = i_Read1;
  assign w_read2     = i_Read2;
`endif

  // stall already excludes flush, so this equals flush | hazard
  assign w_bubble = i_flush || o_stall;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_valid         <= 1'b0;
      o_pc            <= '0;
      o_rs1           <= '0;
      o_rs2           <= '0;
      o_rd            <= '0;
      o_imm           <= '0;
      o_Read1         <= '0;
      o_Read2         <= '0;
      o_ctrl_RegWrite <= 1'b0;
      o_ctrl_MemRead  <= 1'b0;
      o_ctrl          <= '0;
    end else if (w_bubble) begin
      o_valid         <= 1'b0;
      o_pc            <= '0;
      o_rs1           <= '0;
      o_rs2           <= '0;
      o_rd            <= '0;
      o_imm           <= '0;
      o_Read1         <= '0;
      o_Read2         <= '0;
      o_ctrl_RegWrite <= 1'b0;
      o_ctrl_MemRead  <= 1'b0;
      o_ctrl          <= '0;
    end else begin
      o_valid         <= i_valid;
      o_pc            <= i_pc;
      o_rs1           <= i_rs1;
      o_rs2           <= i_rs2;
      o_rd            <= i_rd;
      o_imm           <= i_imm;
      o_Read1         <= w_read1;
      o_Read2         <= w_read2;
      o_ctrl_RegWrite <= i_valid && i_ctrl_RegWrite;
      o_ctrl_MemRead  <= i_valid && i_ctrl_MemRead;
      o_ctrl          <= i_valid ? i_ctrl : '0;
    end
  end

endmodule

`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/PC/immediate width.
REQ-002 SHALL have parameter CTRL_WIDTH, default 8, width of pass-through EX/MEM/WB control bundle.
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have n_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have i_valid  input  1  decode-stage instruction valid.
REQ-006 SHALL have i_pc  input  DATA_WIDTH  decode-stage PC.
REQ-007 SHALL have i_rs1, i_rs2, i_rd  input  5 each  decode register indices.
REQ-008 SHALL have i_imm  input  DATA_WIDTH  decoded immediate.
REQ-009 SHALL have i_Read1, i_Read2  input  DATA_WIDTH  register-file read data for i_rs1/i_rs2.
REQ-010 SHALL have i_ctrl_RegWrite, i_ctrl_MemRead  input  1 each  decode control.
REQ-011 SHALL have i_ctrl  input  CTRL_WIDTH  remaining control, passed through.
REQ-012 SHALL have i_wb_rd  input  5, i_wb_WriteData  input  DATA_WIDTH, i_wb_RegWrite  input  1: writeback port (same signals driving register-file write).
REQ-013 SHALL have i_flush  input  1  taken branch/jump resolved in EX; kills decode instruction.
REQ-014 SHALL have o_stall  output  1  combinational; holds PC and IF/ID register when high.
REQ-015 SHALL have registered outputs o_valid(1), o_pc, o_rs1, o_rs2, o_rd, o_imm, o_Read1, o_Read2, o_ctrl_RegWrite, o_ctrl_MemRead, o_ctrl (widths match inputs).

Function
REQ-016 Hazard SHALL = o_valid & o_ctrl_MemRead & o_rd!=0 & i_valid & (o_rd==i_rs1 | o_rd==i_rs2).
REQ-017 o_stall SHALL = hazard & !i_flush, same cycle, no register delay.
REQ-018 Priority per edge SHALL be: i_flush > hazard > capture.
REQ-019 Flush or hazard SHALL insert bubble: o_valid, o_ctrl_RegWrite, o_ctrl_MemRead, o_ctrl <= 0; data fields don't-care but SHALL be loaded with 0.
REQ-020 Capture SHALL load all o_* from i_* with one-cycle latency; o_valid <= i_valid; if i_valid=0, control outputs <= 0.
REQ-021 Stall SHALL last exactly one cycle per load-use pair (bubble clears o_ctrl_MemRead, releasing hazard next cycle).
REQ-022 Reads or writes of x0 SHALL never raise hazard or bypass.
REQ-023 Back-to-back loads with dependency chain SHALL each produce one bubble; no lost or duplicated instruction.

Reset
REQ-024 n_rst low SHALL asynchronously force every o_* register to 0 (o_valid=0, all controls 0); o_stall then 0.
REQ-025 Reset assertion mid-stall SHALL drop the pending bubble/instruction; first post-reset edge captures normally.

Configuration
REQ-026 Macro ID_EX_WB_BYPASS_EN defined: operand captured SHALL be i_wb_WriteData when i_wb_RegWrite & i_wb_rd!=0 & i_wb_rd==i_rsN, else i_ReadN (covers same-cycle write/read in register file).
REQ-027 Macro undefined: o_ReadN SHALL capture i_ReadN unmodified; i_wb_* ports remain present, unused.

Structure
REQ-028 Shared package rv32_pipe_pkg SHALL hold DATA_WIDTH/CTRL_WIDTH defaults, REG_X0 constant and control-bundle bit-position constants.
REQ-029 Load-use detection SHALL be a sub-module hazard_unit (combinational, inputs EX rd/MemRead/valid and ID rs1/rs2/valid/flush, output o_stall).

Verification
REQ-030 Reset: n_rst=0 async mid-cycle -> all outputs 0 immediately, o_stall=0.
REQ-031 Load-use: EX lw rd=5, ID add rs1=5 -> o_stall=1 one cycle, next o_valid=0 bubble, following cycle add captured, o_stall=0.
REQ-032 Flush vs hazard: same load-use plus i_flush=1 -> o_stall=0, bubble inserted, add not captured.
REQ-033 x0: EX lw rd=0, ID rs1=0 -> no stall; with bypass, i_wb_rd=0 data 0xDEADBEEF -> o_Read1 = i_Read1.
REQ-034 Bypass (ID_EX_WB_BYPASS_EN): i_wb_rd=7, data 0x12345678, RegWrite=1, i_rs2=7, i_Read2=0 -> o_Read2=0x12345678; macro off -> 0.
REQ-035 Capture: i_valid=0 with i_ctrl_RegWrite=1 -> o_valid=0, o_ctrl_RegWrite=0.
